esampler_period_meter: RTL and testbench

Multi-channel successor to the dual-edge hit sampler in the low-frequency tracking loop. The oscillator clock samples NUM_CH asynchronous reference inputs, detects each reference rising edge as a one-cycle hit, and measures the reference period in oscillator cycles. The period is reported either per single reference period or accumulated over 2^AVG_LOG2 periods. The outputs feed the tracking-loop accumulator and replace per-channel ad-hoc hit logic.

---
 rtl/esampler_period_meter.sv | 125 ++++++++++++
 tb/tb_esampler_period_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esampler_period_meter.sv
// Multi-channel reference period meter: synchronises each aux_clk, flags rising edges as hits
// and measures the reference period (single or 2^AVG_LOG2 periods summed) in osc_out_star cycles.
module esampler_period_meter #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic                    osc_out_star,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       aux_clk,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    accumu_select,
  input  logic [NUM_CH-1:0]       clear_ovf,
  output logic [NUM_CH-1:0]       hit,
  output logic [NUM_CH-1:0]       period_valid,
  output logic [NUM_CH*CNT_W-1:0] period_cnt,
  output logic [NUM_CH-1:0]       overflow
);

  localparam int               K_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [K_W-1:0]   K_LAST  = K_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   hit_d, hit_q;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [K_W-1:0]         k_q, k_d;
    logic                   mode_q, mode_d;
    logic [CNT_W-1:0]       res_q, res_d;
    logic                   vld_q, vld_d;
    logic                   ovf_q, ovf_d;
    logic                   ovf_set;

    assign hit_d = sync_q[SYNC_STAGES-1] & ~prev_q & ch_en[c];

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      k_d     = k_q;
      mode_d  = mode_q;
      res_d   = res_q;
      vld_d   = 1'b0;
      ovf_set = 1'b0;
      if (!ch_en[c]) begin
        state_d = S_IDLE;
        acc_d   = '0;
        k_d     = '0;
      end else begin
        case (state_q)
          S_IDLE: state_d = S_ARM;
          S_ARM: begin
            if (hit_d) begin
              acc_d   = CNT_W'(1);
              k_d     = '0;
              mode_d  = accumu_select;
              state_d = S_MEAS;
            end
          end
          S_MEAS: begin
            // A hit takes priority over saturation: it closes or advances the window.
            if (hit_d) begin
              if (!mode_q || (k_q == K_LAST)) begin
                res_d  = acc_q;
                vld_d  = 1'b1;
                acc_d  = CNT_W'(1);
                k_d    = '0;
                mode_d = accumu_select;
              end else begin
                k_d   = k_q + K_W'(1);
                acc_d = acc_q + CNT_W'(1);
              end
            end else if (acc_q == ACC_MAX) begin
              ovf_set = 1'b1;
              acc_d   = '0;
              k_d     = '0;
              state_d = S_ARM;
            end else begin
              acc_d = acc_q + CNT_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      ovf_d = ovf_set ? 1'b1 : (clear_ovf[c] ? 1'b0 : ovf_q);
    end

    always_ff @(posedge osc_out_star or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        sync_q  <= '0;
        prev_q  <= 1'b0;
        hit_q   <= 1'b0;
        acc_q   <= '0;
        k_q     <= '0;
        mode_q  <= 1'b0;
        res_q   <= '0;
        vld_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sync_q  <= {sync_q[SYNC_STAGES-2:0], aux_clk[c]};
        prev_q  <= sync_q[SYNC_STAGES-1];
        hit_q   <= hit_d;
        acc_q   <= acc_d;
        k_q     <= k_d;
        mode_q  <= mode_d;
        res_q   <= res_d;
        vld_q   <= vld_d;
        ovf_q   <= ovf_d;
      end
    end

    assign hit[c]                       = hit_q;
    assign period_valid[c]              = vld_q;
    assign period_cnt[c*CNT_W +: CNT_W] = res_q;
    assign overflow[c]                  = ovf_q;
  end

endmodule

// File: tb/tb_esampler_period_meter.sv
// Directed bench for esampler_period_meter: a 2-channel default instance plus a
// 1-channel CNT_W=4 instance for saturation behaviour.
module tb_esampler_period_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  aux;
  logic [1:0]  ch_en;
  logic        accumu_select;
  logic [1:0]  clear_ovf;
  logic [1:0]  hit, period_valid, overflow;
  logic [31:0] period_cnt;
  logic        en_b, clr_b, hit_b, vld_b, ovf_b;
  logic [3:0]  cnt_b;

  int per [3];
  int ph  [3];
  int cyc;
  int n_checks, n_errors;
  int q0[$], q1[$], s0[$], s1[$];
  int hc0, hc1, hcb, vcb;
  bit bad_rst;

  esampler_period_meter u_dut (
    .osc_out_star (clk),
    .rst_n        (rst_n),
    .aux_clk      (aux[1:0]),
    .ch_en        (ch_en),
    .accumu_select(accumu_select),
    .clear_ovf    (clear_ovf),
    .hit          (hit),
    .period_valid (period_valid),
    .period_cnt   (period_cnt),
    .overflow     (overflow)
  );

  esampler_period_meter #(.NUM_CH(1), .CNT_W(4)) u_dut_ovf (
    .osc_out_star (clk),
    .rst_n        (rst_n),
    .aux_clk      (aux[2]),
    .ch_en        (en_b),
    .accumu_select(accumu_select),
    .clear_ovf    (clr_b),
    .hit          (hit_b),
    .period_valid (vld_b),
    .period_cnt   (cnt_b),
    .overflow     (ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference generators: period per[c] cycles, high for per[c]/2, changes on negedge.
  initial begin
    aux = '0;
    for (int c = 0; c < 3; c++) ph[c] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (per[c] == 0) begin
          aux[c] = 1'b0;
          ph[c]  = 0;
        end else begin
          aux[c] = (ph[c] < per[c] / 2) ? 1'b1 : 1'b0;
          ph[c]  = (ph[c] == per[c] - 1) ? 0 : ph[c] + 1;
        end
      end
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    hc0 = 0; hc1 = 0; hcb = 0; vcb = 0; bad_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n && (hit != 0 || period_valid != 0 || period_cnt != 0 || overflow != 0 ||
                     hit_b || vld_b || ovf_b || cnt_b != 0))
        bad_rst = 1'b1;
      if (hit[0]) hc0++;
      if (hit[1]) hc1++;
      if (hit_b)  hcb++;
      if (vld_b)  vcb++;
      if (period_valid[0]) begin q0.push_back(int'(period_cnt[15:0]));  s0.push_back(cyc); end
      if (period_valid[1]) begin q1.push_back(int'(period_cnt[31:16])); s1.push_back(cyc); end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int m0, m1, h0, h1, mb, base;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1; ch_en = 2'b11; accumu_select = 1'b0; clear_ovf = '0;
    en_b = 1'b1; clr_b = 1'b0;
    per[0] = 6; per[1] = 5; per[2] = 4;

    // Reset held with references toggling
    #2 rst_n = 1'b0;
    cycles(20);
    check("rst_any_output", 32'(bad_rst), 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_flags", {26'd0, hit, period_valid, overflow}, 0);
    check("rst_small_inst", {25'd0, hit_b, vld_b, ovf_b, cnt_b}, 0);
    per[0] = 0; per[1] = 0; per[2] = 0;
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    check("no_hit_after_release", hc0 + hc1 + hcb, 0);

    // Saturation on CNT_W=4 with a 20-cycle reference
    mb = hcb;
    per[2] = 20;
    cycles(17);
    check("ovf_before_sat", 32'(ovf_b), 0);
    cycles(1);
    check("ovf_set", 32'(ovf_b), 1);
    cycles(1);
    clr_b = 1'b1;
    cycles(1);
    clr_b = 1'b0;
    check("ovf_cleared", 32'(ovf_b), 0);
    cycles(17);
    clr_b = 1'b1;
    cycles(1);
    clr_b = 1'b0;
    check("ovf_set_beats_clear", 32'(ovf_b), 1);
    check("ovf_no_valid", vcb, 0);
    check("ovf_hits", hcb - mb, 2);
    per[2] = 0; en_b = 1'b0;

    // Hit latency and single-period measurement, period 10
    cycles(5);
    per[0] = 10;
    cycles(2);
    check("hit_lat_early", 32'(hit[0]), 0);
    cycles(1);
    check("hit_lat", 32'(hit[0]), 1);
    cycles(1);
    check("hit_one_cycle", 32'(hit[0]), 0);
    m0 = q0.size(); h0 = hc0;
    cycles(45);
    check("p10_count", q0.size() - m0, 4);
    for (int i = 0; i < 4; i++)
      check("p10_value", (q0.size() > m0 + i) ? q0[m0 + i] : -1, 10);
    for (int i = 0; i < 3; i++)
      check("p10_spacing", (s0.size() > m0 + i + 1) ? s0[m0 + i + 1] - s0[m0 + i] : -1, 10);
    check("p10_hits", hc0 - h0, 4);
    check("p10_held", period_cnt[15:0], 10);

    // Accumulate mode, then drop accumu_select mid-window
    accumu_select = 1'b1;
    m0 = q0.size();
    cycles(92);
    check("acc_count", q0.size() - m0, 3);
    check("acc_first_closes_single", (q0.size() > m0) ? q0[m0] : -1, 10);
    check("acc_value_a", (q0.size() > m0 + 1) ? q0[m0 + 1] : -1, 40);
    check("acc_value_b", (q0.size() > m0 + 2) ? q0[m0 + 2] : -1, 40);
    check("acc_spacing", (s0.size() > m0 + 2) ? s0[m0 + 2] - s0[m0 + 1] : -1, 40);
    accumu_select = 1'b0;
    m0 = q0.size();
    cycles(45);
    check("sel_change_count", q0.size() - m0, 2);
    check("sel_change_cur", (q0.size() > m0) ? q0[m0] : -1, 40);
    check("sel_change_next", (q0.size() > m0 + 1) ? q0[m0 + 1] : -1, 10);

    // Two channels in parallel: periods 7 and 12
    ch_en = 2'b00; per[0] = 0; per[1] = 0;
    cycles(10);
    ch_en = 2'b11;
    cycles(2);
    per[0] = 7; per[1] = 12;
    base = cyc; m0 = q0.size(); m1 = q1.size();
    cycles(40);
    check("ind_ch0_count", q0.size() - m0, 5);
    check("ind_ch1_count", q1.size() - m1, 3);
    for (int i = 0; i < 5; i++)
      check("ind_ch0_value", (q0.size() > m0 + i) ? q0[m0 + i] : -1, 7);
    for (int i = 0; i < 3; i++)
      check("ind_ch1_value", (q1.size() > m1 + i) ? q1[m1 + i] : -1, 12);

    // Disable ch1 mid-window, then re-enable
    ch_en[1] = 1'b0;
    m0 = q0.size(); m1 = q1.size(); h1 = hc1;
    cycles(20);
    check("dis_ch1_no_valid", q1.size() - m1, 0);
    check("dis_ch1_no_hit", hc1 - h1, 0);
    check("dis_ch1_held", period_cnt[31:16], 12);
    check("dis_ch0_count", q0.size() - m0, 3);
    check("dis_ch0_value", (q0.size() > m0 + 2) ? q0[m0 + 2] : -1, 7);
    ch_en[1] = 1'b1;
    m1 = q1.size();
    cycles(20);
    check("reen_count", q1.size() - m1, 1);
    check("reen_value", (q1.size() > m1) ? q1[m1] : -1, 12);
    check("reen_time", (s1.size() > m1) ? s1[m1] - base : -1, 75);

    // Asynchronous reset in the middle of a window
    #2 rst_n = 1'b0;
    #1;
    check("arst_period_cnt", period_cnt, 0);
    check("arst_flags", {26'd0, hit, period_valid, overflow}, 0);
    check("arst_small_ovf", 32'(ovf_b), 0);
    per[0] = 0; per[1] = 0;
    cycles(4);
    rst_n = 1'b1;
    cycles(5);
    per[0] = 7;
    base = cyc; m0 = q0.size();
    cycles(12);
    check("rearm_count", q0.size() - m0, 1);
    check("rearm_value", (q0.size() > m0) ? q0[m0] : -1, 7);
    check("rearm_time", (s0.size() > m0) ? s0[m0] - base : -1, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
